// File: rtl/redmule_mx_slot_packer_pkg.sv
// Shared types and constants for the MX output slot packer.
// State encoding plus slot-pairing and shared-exponent width constants.
package redmule_mx_slot_packer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } mx_pack_state_e;

  localparam int unsigned MX_SLOTS_PER_BEAT = 2;
  localparam int unsigned MX_SHARED_EXP_W   = 8;

endpackage

// File: rtl/redmule_mx_slot_packer.sv
// Pairs 256-bit FP8 slots into 512-bit beats with one shared exponent (FP16: one slot per beat).
// Optional beat/partial counters under REDMULE_MX_PACK_CNT_EN.
module redmule_mx_slot_packer
  import redmule_mx_slot_packer_pkg::*;
#(
  parameter int unsigned DATAW_ALIGN = 512,
  parameter int unsigned MX_DATA_W   = 256,
  parameter int unsigned MX_EXP_W    = MX_SHARED_EXP_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   mx_enable_i,
  input  logic                   flush_i,
  input  logic                   slot_valid_i,
  output logic                   slot_ready_o,
  input  logic [MX_DATA_W-1:0]   slot_data_i,
  input  logic [MX_EXP_W-1:0]    slot_exp_i,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic [DATAW_ALIGN-1:0] data_o,
  output logic                   exp_valid_o,
  input  logic                   exp_ready_i,
  output logic [MX_EXP_W-1:0]    exp_o,
  output logic                   exp_mismatch_o,
  output logic                   idle_o
`ifdef REDMULE_MX_PACK_CNT_EN
  ,
  output logic [31:0]            beat_cnt_o,
  output logic [15:0]            partial_cnt_o
`endif
);

  mx_pack_state_e state_q, state_d;
  logic [MX_DATA_W-1:0]   lower_q, lower_d;
  logic [MX_EXP_W-1:0]    lower_exp_q, lower_exp_d;
  logic [DATAW_ALIGN-1:0] beat_q, beat_d;
  logic [MX_EXP_W-1:0]    exp_q, exp_d;
  logic                   data_sent_q, data_sent_d;
  logic                   exp_sent_q, exp_sent_d;
  logic                   mismatch_q, mismatch_d;
  logic                   flushed_q, flushed_d;

  logic data_hs, exp_hs, retire, accept, take_first;

  assign data_valid_o = (state_q == FULL) && !data_sent_q;
  assign exp_valid_o  = (state_q == FULL) && mx_enable_i && !exp_sent_q;
  assign data_hs      = data_valid_o && data_ready_i;
  assign exp_hs       = exp_valid_o && exp_ready_i;

  assign retire = (state_q == FULL) && (data_sent_q || data_hs) &&
                  (!mx_enable_i || exp_sent_q || exp_hs);

  // Ready looks through the output handshakes so a retiring beat can take a slot in the same cycle.
  assign slot_ready_o = (state_q != FULL) || retire;
  assign accept       = slot_valid_i && slot_ready_o;
  assign take_first   = accept && ((state_q == EMPTY) || (state_q == FULL && retire));

  always_comb begin
    state_d     = state_q;
    lower_d     = lower_q;
    lower_exp_d = lower_exp_q;
    beat_d      = beat_q;
    exp_d       = exp_q;
    data_sent_d = data_sent_q;
    exp_sent_d  = exp_sent_q;
    mismatch_d  = mismatch_q;
    flushed_d   = flushed_q;

    case (state_q)
      EMPTY: ;
      HALF: begin
        if (accept) begin
          beat_d      = {slot_data_i, lower_q};
          exp_d       = lower_exp_q;
          flushed_d   = 1'b0;
          data_sent_d = 1'b0;
          exp_sent_d  = 1'b0;
          state_d     = FULL;
          if (slot_exp_i != lower_exp_q) mismatch_d = 1'b1;
        end else if (flush_i) begin
          beat_d      = {{(DATAW_ALIGN-MX_DATA_W){1'b0}}, lower_q};
          exp_d       = lower_exp_q;
          flushed_d   = 1'b1;
          data_sent_d = 1'b0;
          exp_sent_d  = 1'b0;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (retire) begin
          data_sent_d = 1'b0;
          exp_sent_d  = 1'b0;
          state_d     = EMPTY;
        end else begin
          data_sent_d = data_sent_q || data_hs;
          exp_sent_d  = exp_sent_q || exp_hs;
        end
      end
      default: state_d = EMPTY;
    endcase

    // First slot of a beat, whether arriving into EMPTY or behind a retiring beat.
    if (take_first) begin
      data_sent_d = 1'b0;
      exp_sent_d  = 1'b0;
      if (mx_enable_i) begin
        lower_d     = slot_data_i;
        lower_exp_d = slot_exp_i;
        state_d     = HALF;
      end else begin
        beat_d    = {{(DATAW_ALIGN-MX_DATA_W){1'b0}}, slot_data_i};
        flushed_d = 1'b0;
        state_d   = FULL;
      end
    end

    if (clear_i) begin
      state_d     = EMPTY;
      lower_d     = '0;
      lower_exp_d = '0;
      beat_d      = '0;
      exp_d       = '0;
      data_sent_d = 1'b0;
      exp_sent_d  = 1'b0;
      mismatch_d  = 1'b0;
      flushed_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      lower_q     <= '0;
      lower_exp_q <= '0;
      beat_q      <= '0;
      exp_q       <= '0;
      data_sent_q <= 1'b0;
      exp_sent_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lower_q     <= lower_d;
      lower_exp_q <= lower_exp_d;
      beat_q      <= beat_d;
      exp_q       <= exp_d;
      data_sent_q <= data_sent_d;
      exp_sent_q  <= exp_sent_d;
      mismatch_q  <= mismatch_d;
      flushed_q   <= flushed_d;
    end
  end

  assign data_o         = beat_q;
  assign exp_o          = exp_q;
  assign exp_mismatch_o = mismatch_q;
  assign idle_o         = (state_q == EMPTY);

`ifdef REDMULE_MX_PACK_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [15:0] partial_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q    <= '0;
      partial_cnt_q <= '0;
    end else if (clear_i) begin
      beat_cnt_q    <= '0;
      partial_cnt_q <= '0;
    end else if (retire) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
      if (flushed_q) partial_cnt_q <= partial_cnt_q + 16'd1;
    end
  end

  assign beat_cnt_o    = beat_cnt_q;
  assign partial_cnt_o = partial_cnt_q;
`endif

endmodule
